// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Shares one Wishbone slave port between two masters: the LM32 instruction
//   bus (m0) and the LM32 data bus (m1). Arbitration is round-robin. A bus
//   watchdog returns an error to the granted master when the slave never acks,
//   then releases the bus.
//
// Handshake: Wishbone classic. A master request is valid while cyc & stb are
//   high. The slave completes a beat by raising s_ack_i for one cycle. The
//   arbiter forwards that ack to the granted master with zero latency. The
//   granted master keeps the bus until it drops cyc, even between beats.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   mN_adr/dat/sel/we/cyc/stb_i   master N request (N = 0,1)
//   mN_dat_o            slave read data, broadcast to both masters
//   mN_ack_o, mN_err_o  ack / bus-timeout error to master N
//   s_adr/dat/sel/we/cyc/stb_o    request forwarded to the slave
//   s_dat_i, s_ack_i    slave read data and ack
//   grant_o             one-hot grant: 01 = m0, 10 = m1, 00 = none
//   timeout_o           one-cycle pulse when the watchdog fires
//   state_o             FSM state (0 IDLE, 1 BUSY, 2 ERR), for observation
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int ADR_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       grant_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  // A zero timeout disables the watchdog. The counter keeps a 1-bit width then,
  // so that no zero-width vector is declared.
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    state;
  logic [1:0]    grant;
  logic          last_m1;   // 1 when m1 held the bus most recently
  logic [CW-1:0] wd_cnt;

  logic req0, req1;
  logic busy, sel_m1;
  logic g_cyc, g_stb;

  assign req0   = m0_cyc_i & m0_stb_i;
  assign req1   = m1_cyc_i & m1_stb_i;
  assign busy   = (state == BUSY);
  assign sel_m1 = grant[1];
  assign g_cyc  = sel_m1 ? m1_cyc_i : m0_cyc_i;
  assign g_stb  = sel_m1 ? m1_stb_i : m0_stb_i;

  // The slave side is driven only in BUSY. IDLE and ERR present an idle bus.
  assign s_adr_o = busy ? (sel_m1 ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = busy ? (sel_m1 ? m1_dat_i : m0_dat_i) : '0;
  assign s_sel_o = busy ? (sel_m1 ? m1_sel_i : m0_sel_i) : '0;
  assign s_we_o  = busy & (sel_m1 ? m1_we_i : m0_we_i);
  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // The ack passes straight through in BUSY. A stray ack in IDLE or ERR is dropped.
  assign m0_ack_o = busy & grant[0] & s_ack_i;
  assign m1_ack_o = busy & grant[1] & s_ack_i;
  assign m0_err_o = (state == ERR) & grant[0];
  assign m1_err_o = (state == ERR) & grant[1];

  assign timeout_o = (state == ERR);
  assign grant_o   = grant;
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last_m1 <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (req0 | req1) begin
            state <= BUSY;
            // m0 wins when it is alone, or when both request and m1 went last.
            if (req0 && (!req1 || last_m1)) grant <= 2'b01;
            else                            grant <= 2'b10;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state   <= IDLE;
            last_m1 <= grant[1];
            grant   <= 2'b00;
            wd_cnt  <= '0;
          end else if (WD_EN && g_stb && !s_ack_i) begin
            // An ack on the final count cycle takes the else branch and wins.
            if (wd_cnt == WD_LAST) begin
              state  <= ERR;
              wd_cnt <= '0;
            end else begin
              wd_cnt <= wd_cnt + CW'(1);
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        ERR: begin
          state   <= IDLE;
          last_m1 <= grant[1];
          grant   <= 2'b00;
          wd_cnt  <= '0;
        end
        default: begin
          state  <= IDLE;
          grant  <= 2'b00;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int ADR_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ADR_W-1:0] m0_adr_i = '0, m1_adr_i = '0;
  logic [31:0]      m0_dat_i = '0, m1_dat_i = '0;
  logic [3:0]       m0_sel_i = '0, m1_sel_i = '0;
  logic             m0_we_i = 0, m0_cyc_i = 0, m0_stb_i = 0;
  logic             m1_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0;
  logic [31:0]      m0_dat_o, m1_dat_o;
  logic             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [31:0]      s_dat_i = '0;
  logic             s_ack_i = 1'b0;
  logic [1:0]       grant_o;
  logic             timeout_o;
  logic [1:0]       state_o;

  // {master id (1 = m1), read data} expected with each ack
  logic [32:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  wb_rr_arbiter #(.ADR_W(ADR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after the rising edge. Outputs are sampled 3 ns after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    s_ack_i = 0; s_dat_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic m0_req(input logic [31:0] adr, input logic we);
    m0_adr_i = adr; m0_we_i = we; m0_dat_i = $urandom; m0_sel_i = 4'hF;
    m0_cyc_i = 1; m0_stb_i = 1;
  endtask

  task automatic m1_req(input logic [31:0] adr, input logic we);
    m1_adr_i = adr; m1_we_i = we; m1_dat_i = $urandom; m1_sel_i = 4'hF;
    m1_cyc_i = 1; m1_stb_i = 1;
  endtask

  task automatic m0_drop();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
  endtask

  task automatic m1_drop();
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
  endtask

  // The slave acks this cycle with data. The ack is expected at master `who`.
  task automatic slave_ack(input logic who, input logic [31:0] data);
    s_ack_i = 1; s_dat_i = data;
    exp_q.push_back({who, data});
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [32:0] e;
    #2;
    if (m0_ack_o || m1_ack_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_onehot", {62'd0, m1_ack_o, m0_ack_o}, e[32] ? 64'd2 : 64'd1);
        chk("ack_data", {31'd0, m1_ack_o, (m1_ack_o ? m1_dat_o : m0_dat_o)}, {31'd0, e});
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] exp_g;
  logic [31:0] rd;

  initial begin
    // Reset state
    do_reset();
    sample();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_state", state_o, 2'd0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_acks", {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o, timeout_o}, 0);

    // 1. Single read by m0
    m0_req(32'h2000_0004, 0);                       // cycle 0
    sample();
    chk("t1_c0_grant", grant_o, 2'b00);
    next_cycle(); sample();                         // cycle 1
    chk("t1_c1_grant", grant_o, 2'b01);
    chk("t1_c1_stb", s_stb_o, 1);
    chk("t1_c1_adr", s_adr_o, 32'h2000_0004);
    next_cycle(); sample();                         // cycle 2
    chk("t1_c2_noack", m0_ack_o, 0);
    next_cycle();                                   // cycle 3
    slave_ack(1'b0, 32'h0000_00A5);
    sample();
    chk("t1_c3_ack", m0_ack_o, 1);
    chk("t1_c3_dat", m0_dat_o, 32'h0000_00A5);
    chk("t1_c3_m1ack", m1_ack_o, 0);
    next_cycle(); s_ack_i = 0; m0_drop(); sample(); // cycle 4, still BUSY
    next_cycle(); sample();                         // cycle 5
    chk("t1_idle", grant_o, 2'b00);

    // 2. Simultaneous requests right after reset
    do_reset();
    m0_req($urandom, 0); m1_req(32'h3000_0000, 0);
    next_cycle(); sample();
    chk("t2_first", grant_o, 2'b01);
    slave_ack(1'b0, $urandom);
    sample();
    next_cycle(); s_ack_i = 0; m0_drop(); sample();
    next_cycle(); sample();
    chk("t2_idle_gap", grant_o, 2'b00);
    next_cycle(); sample();
    chk("t2_second", grant_o, 2'b10);
    chk("t2_adr", s_adr_o, 32'h3000_0000);
    slave_ack(1'b1, $urandom);
    sample();
    next_cycle(); s_ack_i = 0; m1_drop(); sample();
    next_cycle(); sample();

    // 3. Continuous single-beat cycles from both masters alternate the grant.
    do_reset();
    m0_req($urandom, 0); m1_req($urandom, 1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      sample();
      chk("t3_idle", grant_o, 2'b00);
      next_cycle(); sample();                       // stb cycle
      chk("t3_grant", grant_o, exp_g);
      next_cycle();                                 // ack cycle
      rd = $urandom;
      slave_ack(exp_g[1], rd);
      sample();
      next_cycle(); s_ack_i = 0;                    // granted master drops
      if (exp_g[1]) m1_drop(); else m0_drop();
      sample();
      next_cycle();                                 // back in IDLE, re-request
      if (exp_g[1]) m1_req($urandom, 1); else m0_req($urandom, 0);
    end
    m0_drop(); m1_drop();
    next_cycle(); next_cycle();

    // 4. Watchdog: m1 write, slave never acks
    do_reset();
    m1_req(32'h4000_0000, 1);
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); sample();
      chk("t4_busy_cyc", s_cyc_o, 1);
      chk("t4_busy_noerr", {m1_err_o, timeout_o}, 0);
    end
    chk("t4_we", s_we_o, 1);
    chk("t4_adr", s_adr_o, 32'h4000_0000);
    next_cycle();                                   // ERR cycle
    s_ack_i = 1; s_dat_i = $urandom;                // late ack, must be dropped
    sample();
    chk("t4_err", {m1_err_o, m0_err_o, timeout_o}, 3'b101);
    chk("t4_err_bus", {s_cyc_o, s_stb_o}, 0);
    chk("t4_err_noack", {m1_ack_o, m0_ack_o}, 0);
    next_cycle(); s_ack_i = 0; m1_drop(); sample();
    chk("t4_idle", {state_o, grant_o, timeout_o, m1_err_o}, 0);

    // 5. Ack on the 8th stb cycle wins over the watchdog.
    do_reset();
    m0_req($urandom, 0);
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); sample();
    end
    next_cycle();
    slave_ack(1'b0, $urandom);
    sample();
    chk("t5_noerr", {m0_err_o, timeout_o}, 0);
    next_cycle(); s_ack_i = 0; sample();
    chk("t5_still_busy", state_o, 2'd1);
    chk("t5_no_timeout", timeout_o, 0);
    m0_drop();
    next_cycle(); next_cycle(); sample();

    // 6. Reset while BUSY with m1 granted
    do_reset();
    m1_req($urandom, 1);
    next_cycle(); sample();
    chk("t6_m1_granted", grant_o, 2'b10);
    next_cycle(); reset = 1;
    next_cycle(); reset = 0;
    m0_req($urandom, 0);
    sample();
    chk("t6_rst_grant", grant_o, 2'b00);
    chk("t6_rst_outs", {s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m1_err_o, timeout_o}, 0);
    chk("t6_rst_adr", s_adr_o, 0);
    next_cycle(); sample();
    chk("t6_m0_first", grant_o, 2'b01);
    m0_drop(); m1_drop();
    next_cycle(); next_cycle();

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
